// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter bank.
package counter_pkg;

  // Default geometry of the bank.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NCH   = 4;

  // Overflow policy at the count boundary.
  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // Action a channel takes in a given cycle, already resolved by priority.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_CLR  = 2'd1,
    ACT_LOAD = 2'd2,
    ACT_STEP = 2'd3
  } ch_act_e;

  // Priority order for a channel: clear beats load, load beats count.
  function automatic ch_act_e resolve_act(input logic clr, input logic ld, input logic en);
    ch_act_e act;
    act = ACT_HOLD;
    if (clr)     act = ACT_CLR;
    else if (ld) act = ACT_LOAD;
    else if (en) act = ACT_STEP;
    return act;
  endfunction

endpackage

// File: rtl/counter_ch.sv
// One up/down counter channel with terminal-count pulse and sticky overflow.
module counter_ch
  import counter_pkg::*;
#(
  parameter int        WIDTH = DEF_WIDTH,
  parameter cnt_mode_e MODE  = CNT_WRAP
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             dn,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] pc,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  ch_act_e          act;

  assign act = resolve_act(clr, ld, en);

  // Next-state computation for count, terminal pulse and sticky flag.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    pc_d  = pc_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    unique case (act)
      ACT_CLR: begin
        pc_d  = '0;
        ovf_d = 1'b0;
      end
      ACT_LOAD: begin
        pc_d = ld_val;
      end
      ACT_STEP: begin
        if (!dn) begin
          // A loaded value above limit counts as already at the boundary.
          if (pc_q >= limit) begin
            tc_d = 1'b1;
            pc_d = (MODE == CNT_SAT) ? limit : '0;
          end else begin
            pc_d = pc_q + WIDTH'(1);
          end
        end else begin
          if (pc_q == '0) begin
            tc_d = 1'b1;
            pc_d = (MODE == CNT_SAT) ? '0 : limit;
          end else begin
            pc_d = pc_q - WIDTH'(1);
          end
        end
        if (tc_d) ovf_d = 1'b1;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clkin) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      pc_q  <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign pc  = pc_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH independent counters sharing one limit and one overflow policy.
module counter_bank
  import counter_pkg::*;
#(
  parameter int        WIDTH = DEF_WIDTH,
  parameter int        NCH   = DEF_NCH,
  parameter cnt_mode_e MODE  = CNT_WRAP
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       dn,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH-1:0]       ld,
  input  logic [NCH*WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0]     limit,
  output logic [NCH*WIDTH-1:0] pc,
  output logic [NCH-1:0]       tc,
  output logic [NCH-1:0]       ovf,
  output logic                 any_tc
);

  // One channel per slice of the packed buses; no carry crosses slices.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    counter_ch #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_ch (
      .clkin  (clkin),
      .rst    (rst),
      .en     (en[i]),
      .dn     (dn[i]),
      .clr    (clr[i]),
      .ld     (ld[i]),
      .ld_val (ld_val[i*WIDTH +: WIDTH]),
      .limit  (limit),
      .pc     (pc[i*WIDTH +: WIDTH]),
      .tc     (tc[i]),
      .ovf    (ovf[i])
    );
  end

  // tc is already registered per channel, so the OR is aligned with it.
  assign any_tc = |tc;

endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank: WRAP and SAT instances driven in parallel against a reference model.
module tb_counter_bank;
  import counter_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   en, dn, clr, ld;
  logic [N*W-1:0] ld_val;
  logic [W-1:0]   limit;

  logic [N*W-1:0] pc_w, pc_s;
  logic [N-1:0]   tc_w, tc_s, ovf_w, ovf_s;
  logic           any_w, any_s;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: index 0 = WRAP instance, 1 = SAT instance.
  int m_pc  [2][N];
  bit m_tc  [2][N];
  bit m_ovf [2][N];

  always #5 clk = ~clk;

  counter_bank #(.WIDTH(W), .NCH(N), .MODE(CNT_WRAP)) dut_wrap (
    .clkin(clk), .rst(rst), .en(en), .dn(dn), .clr(clr), .ld(ld),
    .ld_val(ld_val), .limit(limit), .pc(pc_w), .tc(tc_w), .ovf(ovf_w), .any_tc(any_w)
  );

  counter_bank #(.WIDTH(W), .NCH(N), .MODE(CNT_SAT)) dut_sat (
    .clkin(clk), .rst(rst), .en(en), .dn(dn), .clr(clr), .ld(ld),
    .ld_val(ld_val), .limit(limit), .pc(pc_s), .tc(tc_s), .ovf(ovf_s), .any_tc(any_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply the behavioural rules to the inputs present at this clock edge.
  task automatic model_edge();
    int lim;
    lim = int'(limit);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin
        bit sat;
        sat = (m == 1);
        m_tc[m][i] = 1'b0;
        if (!rst) begin
          m_pc[m][i]  = 0;
          m_ovf[m][i] = 1'b0;
        end else if (clr[i]) begin
          m_pc[m][i]  = 0;
          m_ovf[m][i] = 1'b0;
        end else if (ld[i]) begin
          m_pc[m][i] = int'(ld_val[i*W +: W]);
        end else if (en[i]) begin
          if (!dn[i]) begin
            if (m_pc[m][i] >= lim) begin
              m_tc[m][i] = 1'b1;
              m_pc[m][i] = sat ? lim : 0;
            end else begin
              m_pc[m][i] = (m_pc[m][i] + 1) % 256;
            end
          end else begin
            if (m_pc[m][i] == 0) begin
              m_tc[m][i] = 1'b1;
              m_pc[m][i] = sat ? 0 : lim;
            end else begin
              m_pc[m][i] = m_pc[m][i] - 1;
            end
          end
          if (m_tc[m][i]) m_ovf[m][i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      logic [N*W-1:0] pcv;
      logic [N-1:0]   tcv, ovv;
      logic           anyv;
      bit             any_exp;
      pcv     = (m == 0) ? pc_w  : pc_s;
      tcv     = (m == 0) ? tc_w  : tc_s;
      ovv     = (m == 0) ? ovf_w : ovf_s;
      anyv    = (m == 0) ? any_w : any_s;
      any_exp = 1'b0;
      for (int i = 0; i < N; i++) begin
        check($sformatf("m%0d ch%0d pc", m, i),  32'(pcv[i*W +: W]), m_pc[m][i]);
        check($sformatf("m%0d ch%0d tc", m, i),  32'(tcv[i]),        32'(m_tc[m][i]));
        check($sformatf("m%0d ch%0d ovf", m, i), 32'(ovv[i]),        32'(m_ovf[m][i]));
        any_exp |= m_tc[m][i];
      end
      check($sformatf("m%0d any_tc", m), 32'(anyv), 32'(any_exp));
    end
  endtask

  // One clock: inputs were set at the previous falling edge, outputs checked at the next one.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic quiet_inputs();
    en = '0; dn = '0; clr = '0; ld = '0; ld_val = '0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    limit = 8'd5;
    quiet_inputs();

    // Reset state.
    cycle();
    check("reset pc_w", 32'(pc_w), 0);
    check("reset tc_w", 32'(tc_w), 0);
    check("reset ovf_s", 32'(ovf_s), 0);
    rst = 1'b1;

    // Up count to limit 5 on ch0: WRAP returns to 0, SAT holds at 5.
    en = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check($sformatf("wrap up k%0d pc", k), 32'(pc_w[0 +: W]), k % 6);
      check($sformatf("wrap up k%0d tc", k), 32'(tc_w[0]), (k == 6) ? 1 : 0);
      check($sformatf("sat up k%0d pc", k), 32'(pc_s[0 +: W]), (k < 5) ? k : 5);
      check($sformatf("sat up k%0d tc", k), 32'(tc_s[0]), (k >= 6) ? 1 : 0);
    end
    check("wrap ovf after wrap", 32'(ovf_w[0]), 1);
    check("sat ovf after hold", 32'(ovf_s[0]), 1);
    en = '0; clr = 4'b0001;
    cycle();
    check("sat clr pc", 32'(pc_s[0 +: W]), 0);
    check("sat clr ovf", 32'(ovf_s[0]), 0);
    clr = '0;

    // Load 2 then count down with limit 9: 2,1,0,9 on WRAP.
    limit = 8'd9;
    ld = 4'b0001; ld_val = 32'd2;
    cycle();
    check("load pc", 32'(pc_w[0 +: W]), 2);
    ld = '0; en = 4'b0001; dn = 4'b0001;
    cycle(); check("down 1", 32'(pc_w[0 +: W]), 1);
    cycle(); check("down 0", 32'(pc_w[0 +: W]), 0);
    cycle(); check("down wrap", 32'(pc_w[0 +: W]), 9);
    check("down wrap tc", 32'(tc_w[0]), 1);
    check("down sat hold", 32'(pc_s[0 +: W]), 0);

    // Clear, load and enable together on ch0 while ch1 counts.
    do_reset();
    en = 4'b0011; dn = '0;
    cycle(); cycle();
    clr = 4'b0001; ld = 4'b0001; ld_val = {24'd0, 8'd7};
    cycle();
    check("prio ch0 pc", 32'(pc_w[0 +: W]), 0);
    check("prio ch1 pc", 32'(pc_w[W +: W]), 3);
    quiet_inputs();

    // Reset in the middle of a count.
    do_reset();
    en = 4'b0001;
    cycle(); cycle(); cycle();
    check("pre-reset pc", 32'(pc_w[0 +: W]), 3);
    rst = 1'b0;
    cycle();
    check("mid reset pc", 32'(pc_w[0 +: W]), 0);
    check("mid reset tc", 32'(tc_w[0]), 0);
    check("mid reset ovf", 32'(ovf_w[0]), 0);
    rst = 1'b1;
    cycle();
    check("restart pc", 32'(pc_w[0 +: W]), 1);

    // All channels hit the boundary together.
    do_reset();
    limit = 8'd2; en = 4'hF;
    cycle(); cycle(); cycle();
    check("all tc wrap", 32'(tc_w), 32'hF);
    check("all any wrap", 32'(any_w), 1);
    check("all tc sat", 32'(tc_s), 32'hF);
    en = '0;
    cycle();
    check("all tc gone", 32'(tc_w), 0);
    check("any gone", 32'(any_w), 0);

    // limit 0: every enabled step is a boundary, count stays 0.
    do_reset();
    limit = 8'd0; en = 4'hF; dn = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("lim0 tc", 32'(tc_w), 32'hF);
      check("lim0 pc", 32'(pc_w), 0);
      check("lim0 sat pc", 32'(pc_s), 0);
    end

    // Loaded value above limit is kept, then treated as boundary on up step.
    do_reset();
    limit = 8'd9; ld = 4'b0100; ld_val = {8'd0, 8'd200, 16'd0};
    cycle();
    check("ld above pc", 32'(pc_w[2*W +: W]), 200);
    ld = '0; en = 4'b0100;
    cycle();
    check("above wrap pc", 32'(pc_w[2*W +: W]), 0);
    check("above wrap tc", 32'(tc_w[2]), 1);
    check("above sat pc", 32'(pc_s[2*W +: W]), 9);

    // Randomized traffic, including limit changes and occasional resets.
    do_reset();
    for (int k = 0; k < 500; k++) begin
      rst = ($urandom_range(0, 49) != 0);
      en  = N'($urandom);
      dn  = N'($urandom);
      for (int i = 0; i < N; i++) begin
        clr[i] = ($urandom_range(0, 15) == 0);
        ld[i]  = ($urandom_range(0, 7) == 0);
        ld_val[i*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 19) == 0) limit = W'($urandom_range(0, 12));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 Parameter WIDTH, default 32, shall set the bit width of each channel count.
REQ-002 Parameter NCH, default 4, shall set the number of independent counter channels (1..16).
REQ-003 Parameter MODE, default CNT_WRAP, shall select the overflow policy: CNT_WRAP or CNT_SAT.
REQ-004 Port clkin  in  1  shall be the single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  shall be the reset, synchronous and active-low.
REQ-006 Port en  in  NCH  shall be the per-channel count enable.
REQ-007 Port dn  in  NCH  shall be the per-channel direction: 0 up, 1 down.
REQ-008 Port clr  in  NCH  shall be the per-channel synchronous clear to 0.
REQ-009 Port ld  in  NCH  shall be the per-channel load strobe.
REQ-010 Port ld_val  in  NCH*WIDTH  shall be the per-channel load value; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-011 Port limit  in  WIDTH  shall be the shared terminal value for all channels.
REQ-012 Port pc  out  NCH*WIDTH  shall be the registered channel counts, packed as ld_val.
REQ-013 Port tc  out  NCH  shall be the per-channel terminal-count pulse.
REQ-014 Port ovf  out  NCH  shall be the per-channel sticky overflow/underflow flag.
REQ-015 Port any_tc  out  1  shall be the OR of tc.

Function
REQ-016 Per channel, priority shall be clr > ld > en; ld_val shall appear on pc the cycle after ld.
REQ-017 With en=1, dn=0 and pc<limit, pc shall increment by 1 per cycle.
REQ-018 With en=1, dn=1 and pc>0, pc shall decrement by 1 per cycle.
REQ-019 Up count at pc==limit: CNT_WRAP shall load 0; CNT_SAT shall hold limit.
REQ-020 Down count at pc==0: CNT_WRAP shall load limit; CNT_SAT shall hold 0.
REQ-021 tc[i] shall be a one-cycle registered pulse, asserted the cycle after an enabled step that hit the boundary (REQ-019/020).
REQ-022 ovf[i] shall set with tc[i] and clear only on clr[i] or reset; clr and a boundary event in the same cycle shall leave ovf=0.
REQ-023 A load value above limit shall be accepted unchanged; a subsequent up step shall treat pc>=limit as the boundary.
REQ-024 A limit change shall take effect on the next enabled step; no retroactive tc shall be generated.
REQ-025 Channels shall be fully independent; simultaneous events on different channels shall all be honoured in the same cycle.
REQ-026 Arithmetic shall be unsigned modulo 2^WIDTH, with no carry between channels.
REQ-027 limit==0 shall produce tc on every enabled step, with pc held at 0.

Reset
REQ-028 On rising clkin with rst=0, all pc, tc, ovf and any_tc shall be 0.
REQ-029 Reset shall override clr, ld and en; counting shall resume on the first edge with rst=1.
REQ-030 Reset asserted mid-count shall discard the count; no tc shall be issued for the reset cycle.

Structure
REQ-031 Package counter_pkg shall hold the mode enum (CNT_WRAP, CNT_SAT) and the default WIDTH/NCH constants.
REQ-032 A single sub-module counter_ch (one channel: pc, tc, ovf) shall be instantiated NCH times in a generate loop; any_tc shall be formed at top level.

Verification
REQ-033 WIDTH=8, limit=5, WRAP, en=1 up from reset -> pc 0,1,2,3,4,5,0; tc pulse one cycle after 5->0 step; ovf=1.
REQ-034 SAT, limit=5, up for 8 cycles -> pc holds 5, tc on each held step, ovf=1; then clr -> pc=0, ovf=0.
REQ-035 WRAP, limit=9, ld ld_val=2 then dn=1 en=1 -> pc 2,1,0,9; tc after 0->9.
REQ-036 Same cycle clr=1, ld=1, en=1 on channel 0 while channel 1 counts -> ch0 pc=0; ch1 increments normally.
REQ-037 rst=0 for one cycle at pc=3 with en=1 -> pc=0, tc=0, ovf=0 next cycle; counting restarts at 1.
REQ-038 NCH=4, all channels tc in the same cycle -> tc=4'b1111, any_tc=1 for exactly one cycle.
